// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage register for an in-order RISC-V style pipeline.
// Captures decoded operands and control, detects load-use hazards against
// the instruction held in the register, and forwards results from EX/MEM
// and MEM/WB onto the ALU operands combinationally.
// Optional feature: define ID_EX_FORWARDING_EN to enable operand forwarding;
// without it the operands come straight from the registered data and the
// forwarding inputs are ignored.
module id_ex_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [DATA_W-1:0] rs2_data_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [4:0]        rs1_addr_i,
  input  logic [4:0]        rs2_addr_i,
  input  logic [4:0]        rd_addr_i,
  input  logic [3:0]        ALU_Operation_i,
  input  logic              alu_src_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              valid_i,

  input  logic              stall_i,
  input  logic              flush_i,

  input  logic [4:0]        ex_mem_rd_i,
  input  logic              ex_mem_reg_write_i,
  input  logic [DATA_W-1:0] ex_mem_result_i,
  input  logic [4:0]        mem_wb_rd_i,
  input  logic              mem_wb_reg_write_i,
  input  logic [DATA_W-1:0] mem_wb_data_i,

  output logic [DATA_W-1:0] A_o,
  output logic [DATA_W-1:0] B_o,
  output logic [3:0]        ALU_Operation_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [4:0]        rd_addr_o,
  output logic              reg_write_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              mem_to_reg_o,
  output logic              valid_o,
  output logic              hazard_o
);

  // Everything the stage holds for one instruction. An all-zero value is a
  // bubble: invalid, no side effects, ALU op ADD.
  typedef struct packed {
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [4:0]        rd_addr;
    logic [3:0]        alu_op;
    logic              alu_src;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              valid;
  } stage_t;

  localparam stage_t BUBBLE = '0;

  stage_t            stage_q, stage_d;
  logic              hazard;
  logic [DATA_W-1:0] fa, fb;

  // Load-use hazard: the held load's destination is read by the decoding
  // instruction, so the loaded value cannot be forwarded in time.
  always_comb begin
    hazard = stage_q.valid && stage_q.mem_read && (stage_q.rd_addr != 5'd0) &&
             ((stage_q.rd_addr == rs1_addr_i) || (stage_q.rd_addr == rs2_addr_i)) &&
             valid_i;
  end

  // Next stage contents: flush beats stall, stall beats the hazard bubble.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves stage_d
    // unassigned, which would otherwise infer a latch.
    stage_d = stage_q;
    if (flush_i) begin
      stage_d = BUBBLE;
    end else if (stall_i) begin
      stage_d = stage_q;
    end else if (hazard) begin
      stage_d = BUBBLE;
    end else begin
      stage_d.rs1_data   = rs1_data_i;
      stage_d.rs2_data   = rs2_data_i;
      stage_d.imm        = imm_i;
      stage_d.rs1_addr   = rs1_addr_i;
      stage_d.rs2_addr   = rs2_addr_i;
      stage_d.rd_addr    = rd_addr_i;
      stage_d.alu_op     = ALU_Operation_i;
      stage_d.alu_src    = alu_src_i;
      stage_d.reg_write  = reg_write_i;
      stage_d.mem_read   = mem_read_i;
      stage_d.mem_write  = mem_write_i;
      stage_d.mem_to_reg = mem_to_reg_i;
      stage_d.valid      = valid_i;
    end
  end

  // Stage register; synchronous reset wins over flush and stall, so a reset
  // during a stall discards the held instruction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (!reset) begin
      stage_q <= BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

`ifdef ID_EX_FORWARDING_EN
  // Pick the youngest in-flight writer of src; x0 is never forwarded.
  function automatic logic [DATA_W-1:0] fwd_sel(
    input logic [4:0]        src,
    input logic [DATA_W-1:0] reg_val,
    input logic [4:0]        em_rd,
    input logic              em_we,
    input logic [DATA_W-1:0] em_val,
    input logic [4:0]        wb_rd,
    input logic              wb_we,
    input logic [DATA_W-1:0] wb_val
  );
    if (em_we && (em_rd != 5'd0) && (em_rd == src)) begin
      return em_val;
    end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
      return wb_val;
    end
    return reg_val;
  endfunction

  // Forwarding muxes on both source operands, no added latency.
  always_comb begin
    fa = fwd_sel(stage_q.rs1_addr, stage_q.rs1_data,
                 ex_mem_rd_i, ex_mem_reg_write_i, ex_mem_result_i,
                 mem_wb_rd_i, mem_wb_reg_write_i, mem_wb_data_i);
    fb = fwd_sel(stage_q.rs2_addr, stage_q.rs2_data,
                 ex_mem_rd_i, ex_mem_reg_write_i, ex_mem_result_i,
                 mem_wb_rd_i, mem_wb_reg_write_i, mem_wb_data_i);
  end
`else
  // Without forwarding the operands are the registered data as read in ID.
  always_comb begin
    fa = stage_q.rs1_data;
    fb = stage_q.rs2_data;
  end

  // Forwarding inputs and registered source addresses have no consumer here.
  logic unused_fwd;
  assign unused_fwd = ^{ex_mem_rd_i, ex_mem_reg_write_i, ex_mem_result_i,
                        mem_wb_rd_i, mem_wb_reg_write_i, mem_wb_data_i,
                        stage_q.rs1_addr, stage_q.rs2_addr};
`endif

  // Output drive: operand muxing plus straight copies of the held fields.
  always_comb begin
    A_o             = fa;
    B_o             = stage_q.alu_src ? stage_q.imm : fb;
    store_data_o    = fb;
    ALU_Operation_o = stage_q.alu_op;
    rd_addr_o       = stage_q.rd_addr;
    reg_write_o     = stage_q.reg_write;
    mem_read_o      = stage_q.mem_read;
    mem_write_o     = stage_q.mem_write;
    mem_to_reg_o    = stage_q.mem_to_reg;
    valid_o         = stage_q.valid;
    hazard_o        = hazard;
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios followed by a
// randomized run, all compared against a behavioural model of the stage.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [3:0]  ALU_Operation_i;
  logic        alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, valid_i;
  logic        stall_i, flush_i;
  logic [4:0]  ex_mem_rd_i, mem_wb_rd_i;
  logic        ex_mem_reg_write_i, mem_wb_reg_write_i;
  logic [31:0] ex_mem_result_i, mem_wb_data_i;
  logic [31:0] A_o, B_o, store_data_o;
  logic [3:0]  ALU_Operation_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o, valid_o, hazard_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .ALU_Operation_i(ALU_Operation_i), .alu_src_i(alu_src_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_to_reg_i(mem_to_reg_i), .valid_i(valid_i),
    .stall_i(stall_i), .flush_i(flush_i),
    .ex_mem_rd_i(ex_mem_rd_i), .ex_mem_reg_write_i(ex_mem_reg_write_i),
    .ex_mem_result_i(ex_mem_result_i), .mem_wb_rd_i(mem_wb_rd_i),
    .mem_wb_reg_write_i(mem_wb_reg_write_i), .mem_wb_data_i(mem_wb_data_i),
    .A_o(A_o), .B_o(B_o), .ALU_Operation_o(ALU_Operation_o),
    .store_data_o(store_data_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .valid_o(valid_o), .hazard_o(hazard_o)
  );

  // Reference model: the instruction the stage is expected to hold.
  typedef struct {
    logic [31:0] rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  op;
    logic        src, rw, mr, mw, m2r, v;
  } instr_t;

  instr_t m;

  function automatic instr_t bubble();
    instr_t b;
    b.rs1d = 0; b.rs2d = 0; b.imm = 0;
    b.rs1 = 0; b.rs2 = 0; b.rd = 0; b.op = 0;
    b.src = 0; b.rw = 0; b.mr = 0; b.mw = 0; b.m2r = 0; b.v = 0;
    return b;
  endfunction

  function automatic instr_t decoded();
    instr_t d;
    d.rs1d = rs1_data_i; d.rs2d = rs2_data_i; d.imm = imm_i;
    d.rs1 = rs1_addr_i; d.rs2 = rs2_addr_i; d.rd = rd_addr_i;
    d.op = ALU_Operation_i; d.src = alu_src_i; d.rw = reg_write_i;
    d.mr = mem_read_i; d.mw = mem_write_i; d.m2r = mem_to_reg_i; d.v = valid_i;
    return d;
  endfunction

  function automatic logic exp_hazard();
    return m.v && m.mr && (m.rd != 0) &&
           ((m.rd == rs1_addr_i) || (m.rd == rs2_addr_i)) && valid_i;
  endfunction

  // Value the ALU should see for a source register.
  function automatic logic [31:0] exp_operand(logic [4:0] src, logic [31:0] held);
`ifdef ID_EX_FORWARDING_EN
    if (src != 0 && ex_mem_reg_write_i && ex_mem_rd_i == src) return ex_mem_result_i;
    if (src != 0 && mem_wb_reg_write_i && mem_wb_rd_i == src) return mem_wb_data_i;
`endif
    return held;
  endfunction

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    logic [31:0] fa, fb;
    fa = exp_operand(m.rs1, m.rs1d);
    fb = exp_operand(m.rs2, m.rs2d);
    check("A_o", A_o, fa);
    check("B_o", B_o, m.src ? m.imm : fb);
    check("store_data_o", store_data_o, fb);
    check("ALU_Operation_o", ALU_Operation_o, m.op);
    check("rd_addr_o", rd_addr_o, m.rd);
    check("reg_write_o", reg_write_o, m.rw);
    check("mem_read_o", mem_read_o, m.mr);
    check("mem_write_o", mem_write_o, m.mw);
    check("mem_to_reg_o", mem_to_reg_o, m.m2r);
    check("valid_o", valid_o, m.v);
    check("hazard_o", hazard_o, exp_hazard());
  endtask

  // Advance the model with the inputs present at the edge, then return at
  // the following falling edge where new inputs are applied.
  task automatic tick();
    if (!reset)                m = bubble();
    else if (flush_i)          m = bubble();
    else if (stall_i)          m = m;
    else if (exp_hazard())     m = bubble();
    else                       m = decoded();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic probe();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    reset = 1; rs1_data_i = 0; rs2_data_i = 0; imm_i = 0;
    rs1_addr_i = 0; rs2_addr_i = 0; rd_addr_i = 0; ALU_Operation_i = 0;
    alu_src_i = 0; reg_write_i = 0; mem_read_i = 0; mem_write_i = 0;
    mem_to_reg_i = 0; valid_i = 0; stall_i = 0; flush_i = 0;
    ex_mem_rd_i = 0; ex_mem_reg_write_i = 0; ex_mem_result_i = 0;
    mem_wb_rd_i = 0; mem_wb_reg_write_i = 0; mem_wb_data_i = 0;
  endtask

  task automatic rand_inputs();
    rs1_data_i = $urandom; rs2_data_i = $urandom; imm_i = $urandom;
    rs1_addr_i = 5'($urandom_range(0, 7)); rs2_addr_i = 5'($urandom_range(0, 7));
    rd_addr_i = 5'($urandom_range(0, 7)); ALU_Operation_i = 4'($urandom);
    alu_src_i = 1'($urandom); reg_write_i = 1'($urandom);
    mem_read_i = ($urandom_range(0, 2) == 0); mem_write_i = 1'($urandom);
    mem_to_reg_i = 1'($urandom); valid_i = ($urandom_range(0, 3) != 0);
    stall_i = ($urandom_range(0, 9) == 0); flush_i = ($urandom_range(0, 19) == 0);
    ex_mem_rd_i = 5'($urandom_range(0, 7)); ex_mem_reg_write_i = 1'($urandom);
    ex_mem_result_i = $urandom;
    mem_wb_rd_i = 5'($urandom_range(0, 7)); mem_wb_reg_write_i = 1'($urandom);
    mem_wb_data_i = $urandom;
    reset = ($urandom_range(0, 99) >= 3);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    m = bubble();

    // Reset held low for two edges with random inputs: everything zero.
    rand_inputs(); reset = 0;
    tick();
    rand_inputs(); reset = 0;
    tick();
    rand_inputs(); reset = 0;
    probe();
    check("rst A_o", A_o, 0);
    check("rst B_o", B_o, 0);
    check("rst store", store_data_o, 0);
    check("rst valid_o", valid_o, 0);
    check("rst hazard_o", hazard_o, 0);
    tick();

    // Pass-through of a SUB with no forwarding matches.
    clear_inputs();
    rs1_addr_i = 5; rs2_addr_i = 7; rs1_data_i = 32'h10; rs2_data_i = 32'h20;
    rd_addr_i = 9; ALU_Operation_i = 4'b0001; reg_write_i = 1; valid_i = 1;
    probe(); tick();
    clear_inputs();
    probe();
    check("pass A_o", A_o, 32'h10);
    check("pass B_o", B_o, 32'h20);
    check("pass op", ALU_Operation_o, 4'b0001);

    // Forwarding priority on rs1.
    rs1_addr_i = 3; rs2_addr_i = 9; rs1_data_i = 32'h1234; rs2_data_i = 32'h77;
    rd_addr_i = 1; valid_i = 1; reg_write_i = 1;
    tick();
    clear_inputs();
    ex_mem_rd_i = 3; ex_mem_result_i = 32'hAA; ex_mem_reg_write_i = 1;
    mem_wb_rd_i = 3; mem_wb_data_i = 32'hBB; mem_wb_reg_write_i = 1;
    probe();
`ifdef ID_EX_FORWARDING_EN
    check("fwd both", A_o, 32'hAA);
`else
    check("fwd both", A_o, 32'h1234);
`endif
    ex_mem_reg_write_i = 0;
    probe();
`ifdef ID_EX_FORWARDING_EN
    check("fwd memwb", A_o, 32'hBB);
`else
    check("fwd memwb", A_o, 32'h1234);
`endif
    ex_mem_reg_write_i = 1; ex_mem_rd_i = 0; mem_wb_rd_i = 0;
    probe();
    check("fwd x0", A_o, 32'h1234);
    tick();

    // Load-use hazard with rd=4, then the same with rd=0.
    clear_inputs();
    rd_addr_i = 4; mem_read_i = 1; reg_write_i = 1; mem_to_reg_i = 1; valid_i = 1;
    tick();
    clear_inputs();
    rs1_addr_i = 1; rs2_addr_i = 4; valid_i = 1; reg_write_i = 1; rd_addr_i = 2;
    probe();
    check("lu hazard", hazard_o, 1);
    tick();
    clear_inputs();
    probe();
    check("lu valid_o", valid_o, 0);
    check("lu reg_write_o", reg_write_o, 0);
    rd_addr_i = 0; mem_read_i = 1; reg_write_i = 1; valid_i = 1;
    tick();
    clear_inputs();
    rs1_addr_i = 0; rs2_addr_i = 0; valid_i = 1;
    probe();
    check("lu rd0 hazard", hazard_o, 0);
    tick();

    // Stall holds for three cycles, then stall+flush bubbles.
    clear_inputs();
    rs1_addr_i = 8; rs1_data_i = 32'hCAFE; rd_addr_i = 12; valid_i = 1;
    reg_write_i = 1; ALU_Operation_i = 4'b0101;
    tick();
    for (int i = 0; i < 3; i++) begin
      rand_inputs(); reset = 1; stall_i = 1; flush_i = 0;
      ex_mem_rd_i = 0; mem_wb_rd_i = 0;
      probe();
      check("stall rd", rd_addr_o, 12);
      check("stall A", A_o, 32'hCAFE);
      tick();
    end
    rand_inputs(); reset = 1; stall_i = 1; flush_i = 1;
    probe(); tick();
    clear_inputs();
    probe();
    check("flush valid_o", valid_o, 0);

    // Reset during a stall discards the held instruction.
    rs1_addr_i = 2; rs1_data_i = 32'h99; valid_i = 1; rd_addr_i = 3; reg_write_i = 1;
    tick();
    clear_inputs(); stall_i = 1;
    probe(); tick();
    stall_i = 1; reset = 0;
    tick();
    clear_inputs();
    probe();
    check("rst stall valid_o", valid_o, 0);
    check("rst stall A_o", A_o, 0);

    // Immediate operand with rs2 forwarded for the store.
    alu_src_i = 1; imm_i = 32'hFFFFF800; rs2_addr_i = 6; rs2_data_i = 32'h1;
    valid_i = 1; mem_write_i = 1;
    tick();
    clear_inputs();
    ex_mem_rd_i = 6; ex_mem_reg_write_i = 1; ex_mem_result_i = 32'h55;
    probe();
    check("imm B_o", B_o, 32'hFFFFF800);
`ifdef ID_EX_FORWARDING_EN
    check("imm store", store_data_o, 32'h55);
`else
    check("imm store", store_data_o, 32'h1);
`endif
    tick();

    // Randomized run against the model.
    for (int i = 0; i < 500; i++) begin
      rand_inputs();
      probe();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 The block SHALL have the parameter DATA_W, default 32, giving the operand and immediate width.
REQ-002 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have the port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have the decode-side inputs rs1_data_i (DATA_W), rs2_data_i (DATA_W), imm_i (DATA_W), rs1_addr_i (5), rs2_addr_i (5), rd_addr_i (5) and ALU_Operation_i (4).
REQ-005 The block SHALL have the decode-side control inputs alu_src_i, reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i and valid_i, each 1 bit.
REQ-006 The block SHALL have the pipeline-control inputs stall_i and flush_i, each 1 bit.
REQ-007 The block SHALL have the forwarding inputs ex_mem_rd_i (5), ex_mem_reg_write_i (1), ex_mem_result_i (DATA_W), mem_wb_rd_i (5), mem_wb_reg_write_i (1) and mem_wb_data_i (DATA_W).
REQ-008 The block SHALL drive the ALU-side outputs A_o (DATA_W), B_o (DATA_W) and ALU_Operation_o (4).
REQ-009 The block SHALL drive the outputs store_data_o (DATA_W), rd_addr_o (5), reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o and valid_o.
REQ-010 The block SHALL drive the output hazard_o, 1 bit, requesting that the upstream stage hold.

Function
REQ-011 The stage register SHALL capture all decode-side inputs on each rising clk edge when none of flush_i, stall_i or hazard_o is asserted; this gives a latency of one cycle.
REQ-012 Priority SHALL be: flush_i, then stall_i, then hazard_o.
- flush_i=1: load a bubble.
- stall_i=1: hold the current contents.
- hazard_o=1: load a bubble.
REQ-013 A bubble SHALL be defined as valid, reg_write, mem_read, mem_write and mem_to_reg all 0; ALU_Operation 4'b0000 (ADD); all data and address fields 0.
REQ-014 hazard_o SHALL be combinational and asserted when all of the following hold:
- the registered valid and mem_read are 1;
- the registered rd is nonzero;
- the registered rd equals rs1_addr_i or rs2_addr_i;
- valid_i is 1.
REQ-015 The forwarded rs1 value (fa) SHALL be selected as follows:
- ex_mem_result_i if ex_mem_reg_write_i=1, ex_mem_rd_i!=0 and ex_mem_rd_i equals the registered rs1;
- otherwise mem_wb_data_i under the same conditions applied to the mem_wb inputs;
- otherwise the registered rs1 data.
REQ-016 The forwarded rs2 value (fb) SHALL be selected by the same rule, using the registered rs2.
REQ-017 When both forwarding sources match, EX/MEM SHALL win; register x0 SHALL never be forwarded.
REQ-018 A_o SHALL equal fa.
REQ-019 B_o SHALL equal the registered imm when the registered alu_src is 1, and fb otherwise.
REQ-020 store_data_o SHALL always equal fb, regardless of alu_src.
REQ-021 All other outputs SHALL be direct copies of the registered fields.
REQ-022 The forwarding path SHALL be purely combinational, with no added cycle.

Reset
REQ-023 When reset=0 at a rising clk edge, the stage register SHALL load a bubble, overriding flush_i and stall_i.
REQ-024 After reset, all outputs SHALL be 0: A_o, B_o, store_data_o, ALU_Operation_o=4'b0000, rd_addr_o, all control outputs, valid_o and hazard_o.
REQ-025 A reset asserted mid-stall SHALL discard the held instruction.

Configuration
REQ-026 The macro ID_EX_FORWARDING_EN SHALL control forwarding.
- Defined: REQ-015 to REQ-017 apply.
- Undefined: fa and fb equal the registered rs1 and rs2 data; the forwarding inputs are ignored; hazard_o behaviour is unchanged.

Verification
REQ-027 The bench SHALL cover reset: reset=0 for 2 cycles with random inputs -> all outputs 0; valid_o=0.
REQ-028 The bench SHALL cover pass-through: rs1=5, rs2=7, data 0x10 and 0x20, alu_src=0, op=SUB, no matches -> next cycle A_o=0x10, B_o=0x20, ALU_Operation_o=4'b0001.
REQ-029 The bench SHALL cover forwarding priority: registered rs1=3; ex_mem_rd=3 with result 0xAA; mem_wb_rd=3 with data 0xBB; both write enables 1 -> A_o=0xAA. Then drop ex_mem_reg_write -> A_o=0xBB. Then set both rd=0 -> A_o equals the registered data. (Macro undefined: A_o equals the registered data throughout.)
REQ-030 The bench SHALL cover load-use: registered load with rd=4; decode rs2_addr_i=4 with valid_i=1 -> hazard_o=1 and next cycle valid_o=0, reg_write_o=0. Same case with rd=0 -> hazard_o=0.
REQ-031 The bench SHALL cover stall and flush: stall_i=1 for 3 cycles -> outputs held. stall_i=1 with flush_i=1 -> bubble next cycle.
REQ-032 The bench SHALL cover immediates: alu_src=1, imm=0xFFFFF800, rs2 forwarded as 0x55 -> B_o=0xFFFFF800, store_data_o=0x55.
